// File: rtl/unrot_seq.sv
// rtl/unrot_seq.sv - sequential inverse rotator (undoes a prior left/right rotation)
// Optional build macro: UNROT_FAST_EN selects a single-cycle barrel restore
// instead of the default one-bit-per-cycle serial restore.
module unrot_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   amt,
   input  logic             rr,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state;
   logic [SHW-1:0] cnt;
   // Latched original direction: 1 means the word was rotated right,
   // so restoring it means rotating left.
   logic           dir;
   logic           accept;

   // A new request is taken only when the engine is not mid-rotation.
   assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef UNROT_FAST_EN
   logic [2*WIDTH-1:0] dbl_l;
   logic [2*WIDTH-1:0] dbl_r;
   logic [WIDTH-1:0]   rot_full;

   // Full inverse rotation in one step: doubling the word makes the
   // wrapped bits fall into the selected window.
   always_comb begin
      dbl_l    = {a, a} << amt;
      dbl_r    = {a, a} >> amt;
      rot_full = rr ? dbl_l[2*WIDTH-1:WIDTH] : dbl_r[WIDTH-1:0];
   end
`endif

   // Controller, datapath and status flags; busy/done are registered
   // alongside the state so they never depend combinationally on start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         r     <= '0;
         cnt   <= '0;
         dir   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  cnt <= amt;
                  dir <= rr;
`ifdef UNROT_FAST_EN
                  r     <= rot_full;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`else
                  r <= a;
                  if (amt != '0) begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
`endif
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            SHIFT: begin
               // One modular bit step opposite to the original direction.
               if (dir) begin
                  r <= {r[WIDTH-2:0], r[WIDTH-1]};
               end else begin
                  r <= {r[0], r[WIDTH-1:1]};
               end
               cnt <= cnt - 1'b1;
               if (cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= SHIFT;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/unrot_seq.md
UNROT_SEQ -- requirements
Module: unrot_seq

Interface
REQ-001 Parameter WIDTH, default 8: data word width, power of two, at least 2.
REQ-002 Parameter SHW, default 3: amount width; WIDTH SHALL equal 2**SHW.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 start  input  1: request strobe, sampled on clk rising edge.
REQ-006 a  input  WIDTH: previously rotated word to be restored.
REQ-007 amt  input  SHW: rotation amount originally applied to a.
REQ-008 rr  input  1: original direction (1 = a was rotated right, 0 = rotated left).
REQ-009 r  output  WIDTH: registered restored word.
REQ-010 busy  output  1: high while a request is in progress.
REQ-011 done  output  1: one-cycle completion pulse; r is valid while done is high.

Function
REQ-012 The block SHALL apply the inverse rotation to a: rotate left by amt when rr=1, rotate right by amt when rr=0.
REQ-013 States SHALL be IDLE, SHIFT and DONE.
REQ-014 Accept:
  - start=1 in IDLE or DONE SHALL latch a into r, amt into a down-counter cnt and rr into a direction register.
  - Next state SHALL be SHIFT if amt is nonzero, otherwise DONE.
REQ-015 SHIFT behaviour:
  - Each edge SHALL rotate r by one bit in the inverse direction and decrement cnt.
  - On the edge that rotates with cnt=1, the next state SHALL be DONE.
REQ-016 Start is ignored in SHIFT: start=1 there SHALL be ignored, with no effect on r, cnt or the direction register.
REQ-017 DONE SHALL last exactly one cycle and then go to IDLE, unless start=1 in DONE, which SHALL be accepted per REQ-014 (back-to-back operation).
REQ-018 Output timing:
  - busy SHALL equal (state==SHIFT).
  - done SHALL equal (state==DONE).
  - Both SHALL be registered-state decodes with no combinational path from start.
REQ-019 Latency (serial build): done SHALL be high in the cycle after the amt-th rotate edge, i.e. amt+1 edges after the accept edge; for amt=0, the cycle after the accept edge.
REQ-020 r SHALL hold its last value in IDLE and after DONE until the next accept.
REQ-021 Rotation SHALL be modular: bits shifted out of one end SHALL re-enter at the other; no bits are lost or zero-filled.
REQ-022 Inputs a, amt and rr SHALL only be sampled on the accept edge; later changes SHALL NOT affect the in-flight result.

Reset
REQ-023 On reset=1, regardless of clk:
  - state SHALL become IDLE.
  - r, cnt, the direction register, busy and done SHALL become 0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow for the aborted request.
REQ-025 The first accept SHALL be possible on the first rising clk edge after reset deasserts.

Configuration
REQ-026 Macro UNROT_FAST_EN, when defined:
  - The accept edge SHALL load r directly with the fully inverse-rotated word (single-cycle barrel).
  - Next state SHALL always be DONE, so done follows one edge after accept for every amt.
  - busy SHALL never assert.
REQ-027 Without UNROT_FAST_EN, the bit-serial behaviour of REQ-015 and REQ-019 SHALL apply.
REQ-028 Final r values SHALL be identical in both builds.

Verification
REQ-029 Reset then a=0x81, rr=1, amt=1, start pulse -> done high 2 edges after accept (1 rotate), r=0x03.
REQ-030 a=0x96, rr=0, amt=3 -> busy for 3 cycles, then done with r=0xD2; fast build: done 1 edge after accept, r=0xD2, busy never high.
REQ-031 a=0x5A, amt=0, rr=1 -> no busy, done 1 edge after accept, r=0x5A.
REQ-032 a=0x01, rr=0, amt=7, start re-pulsed with a=0xFF during SHIFT -> second start ignored, r=0x02 at done.
REQ-033 Reset asserted mid-SHIFT of a=0xF0, amt=5 -> r=0, busy=0, done=0 immediately, and no later done pulse.
REQ-034 start held high through DONE with a=0x80, rr=1, amt=1 -> new request accepted in DONE, second done with r=0x01, no IDLE gap cycle.
